// File: rtl/ecc_apb_regs.sv
// rtl/ecc_apb_regs.sv - APB register file and operation sequencer for the ECC core
// Optional PSLVERR output is enabled by defining ECC_APB_PSLVERR_EN.
module ecc_apb_regs #(
    parameter int DATA_WIDTH      = 32,
    parameter int AMBA_ADDR_WIDTH = 20,
    parameter int AMBA_WORD       = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [AMBA_ADDR_WIDTH-1:0] PADDR,
    input  logic                       PSEL,
    input  logic                       PENABLE,
    input  logic                       PWRITE,
    input  logic [AMBA_WORD-1:0]       PWDATA,
    output logic [AMBA_WORD-1:0]       PRDATA,
    output logic [1:0]                 ctrl,
    output logic [AMBA_WORD-1:0]       data_in,
    output logic [1:0]                 codeword_width,
    output logic [AMBA_WORD-1:0]       noise,
    output logic                       op_start,
    input  logic                       core_done,
    input  logic [DATA_WIDTH-1:0]      core_data_out,
    input  logic [1:0]                 core_num_errors,
    output logic                       busy
`ifdef ECC_APB_PSLVERR_EN
    ,
    output logic                       PSLVERR
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    localparam logic [2:0] REG_CTRL     = 3'd0;
    localparam logic [2:0] REG_DATA_IN  = 3'd1;
    localparam logic [2:0] REG_CW_WIDTH = 3'd2;
    localparam logic [2:0] REG_NOISE    = 3'd3;
    localparam logic [2:0] REG_DATA_OUT = 3'd4;
    localparam logic [2:0] REG_STATUS   = 3'd5;

    apb_state_e             state_q, state_d;
    logic [1:0]             ctrl_q, ctrl_d;
    logic [AMBA_WORD-1:0]   data_in_q, data_in_d;
    logic [1:0]             cw_width_q, cw_width_d;
    logic [AMBA_WORD-1:0]   noise_q, noise_d;
    logic [DATA_WIDTH-1:0]  data_out_q, data_out_d;
    logic [1:0]             num_err_q, num_err_d;
    logic                   busy_q, busy_d;
    logic                   op_start_q, op_start_d;
    logic [AMBA_WORD-1:0]   prdata_q, prdata_d;

    logic [2:0]             reg_sel;
    logic                   access_edge;
    logic                   wr_en;
    logic                   rw_wr;
    logic                   done_ok;
    logic [AMBA_WORD-1:0]   rdata_mux;
    logic                   unused_addr_bits;

    assign reg_sel          = PADDR[4:2];
    assign unused_addr_bits = ^{PADDR[AMBA_ADDR_WIDTH-1:5], PADDR[1:0]};

    // state_q holds the phase latched at the previous edge, so state_q==SETUP
    // with PENABLE high is the bus access cycle; its closing edge commits writes.
    assign access_edge = (state_q == SETUP) && PSEL && PENABLE;
    assign wr_en       = access_edge && PWRITE;
    assign rw_wr       = wr_en && !busy_q;
    assign done_ok     = core_done && busy_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (PSEL && !PENABLE) state_d = SETUP;
            SETUP: begin
                if (PSEL && PENABLE)       state_d = ACCESS;
                else if (PSEL && !PENABLE) state_d = SETUP;
                else                       state_d = IDLE;
            end
            ACCESS:  state_d = (PSEL && !PENABLE) ? SETUP : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rdata_mux = '0;
        case (reg_sel)
            REG_CTRL:     rdata_mux = {{(AMBA_WORD-2){1'b0}}, ctrl_q};
            REG_DATA_IN:  rdata_mux = data_in_q;
            REG_CW_WIDTH: rdata_mux = {{(AMBA_WORD-2){1'b0}}, cw_width_q};
            REG_NOISE:    rdata_mux = noise_q;
            REG_DATA_OUT: rdata_mux = AMBA_WORD'(data_out_q);
            REG_STATUS:   rdata_mux = {{(AMBA_WORD-3){1'b0}}, num_err_q, busy_q};
            default:      rdata_mux = '0;
        endcase
    end

    always_comb begin
        ctrl_d     = ctrl_q;
        data_in_d  = data_in_q;
        cw_width_d = cw_width_q;
        noise_d    = noise_q;
        data_out_d = data_out_q;
        num_err_d  = num_err_q;
        busy_d     = busy_q;
        op_start_d = 1'b0;
        prdata_d   = (PSEL && !PENABLE) ? rdata_mux : prdata_q;

        if (done_ok) begin
            data_out_d = core_data_out;
            num_err_d  = core_num_errors;
            busy_d     = 1'b0;
        end

        // rw_wr needs busy_q low and done_ok needs it high, so they never collide.
        if (rw_wr) begin
            case (reg_sel)
                REG_CTRL: begin
                    ctrl_d = PWDATA[1:0];
                    if (PWDATA[1:0] != 2'b11) begin
                        op_start_d = 1'b1;
                        busy_d     = 1'b1;
                    end
                end
                REG_DATA_IN:  data_in_d  = PWDATA;
                REG_CW_WIDTH: cw_width_d = PWDATA[1:0];
                REG_NOISE:    noise_d    = PWDATA;
                default:      ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ctrl_q     <= '0;
            data_in_q  <= '0;
            cw_width_q <= '0;
            noise_q    <= '0;
            data_out_q <= '0;
            num_err_q  <= '0;
            busy_q     <= 1'b0;
            op_start_q <= 1'b0;
            prdata_q   <= '0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            data_in_q  <= data_in_d;
            cw_width_q <= cw_width_d;
            noise_q    <= noise_d;
            data_out_q <= data_out_d;
            num_err_q  <= num_err_d;
            busy_q     <= busy_d;
            op_start_q <= op_start_d;
            prdata_q   <= prdata_d;
        end
    end

    assign PRDATA         = prdata_q;
    assign ctrl           = ctrl_q;
    assign data_in        = data_in_q;
    assign codeword_width = cw_width_q;
    assign noise          = noise_q;
    assign op_start       = op_start_q;
    assign busy           = busy_q;

`ifdef ECC_APB_PSLVERR_EN
    logic slv_err;
    always_comb begin
        slv_err = 1'b0;
        if (reg_sel > REG_STATUS)
            slv_err = 1'b1;
        else if (PWRITE && (reg_sel >= REG_DATA_OUT))
            slv_err = 1'b1;
        else if (PWRITE && busy_q)
            slv_err = 1'b1;
    end
    assign PSLVERR = access_edge && slv_err;
`endif

endmodule

// File: tb/tb_ecc_apb_regs.sv
// tb/tb_ecc_apb_regs.sv - directed self-checking bench for ecc_apb_regs
// Exercises the PSLVERR output as well when ECC_APB_PSLVERR_EN is defined.
module tb_ecc_apb_regs;

    logic        clk;
    logic        rst;
    logic [19:0] PADDR;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic [1:0]  ctrl;
    logic [31:0] data_in;
    logic [1:0]  codeword_width;
    logic [31:0] noise;
    logic        op_start;
    logic        core_done;
    logic [31:0] core_data_out;
    logic [1:0]  core_num_errors;
    logic        busy;
`ifdef ECC_APB_PSLVERR_EN
    logic        PSLVERR;
`endif

    int checks = 0;
    int errors = 0;
    logic [31:0] rd;
    logic        slverr_seen;

    ecc_apb_regs #(
        .DATA_WIDTH(32), .AMBA_ADDR_WIDTH(20), .AMBA_WORD(32)
    ) dut (
        .clk(clk), .rst(rst), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .ctrl(ctrl),
        .data_in(data_in), .codeword_width(codeword_width), .noise(noise),
        .op_start(op_start), .core_done(core_done), .core_data_out(core_data_out),
        .core_num_errors(core_num_errors), .busy(busy)
`ifdef ECC_APB_PSLVERR_EN
        , .PSLVERR(PSLVERR)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic apb_write(input logic [19:0] a, input logic [31:0] d);
        @(negedge clk);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
        @(negedge clk);
        PENABLE = 1'b1;
`ifdef ECC_APB_PSLVERR_EN
        slverr_seen = PSLVERR;
`endif
        @(negedge clk);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [19:0] a, output logic [31:0] d);
        @(negedge clk);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
        @(negedge clk);
        PENABLE = 1'b1;
        d = PRDATA;
        @(negedge clk);
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    initial begin
        rst = 1'b1; PADDR = '0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PWDATA = '0; core_done = 1'b0; core_data_out = '0; core_num_errors = '0;
        slverr_seen = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_op_start", {31'b0, op_start}, 32'h0);
        check("rst_prdata", PRDATA, 32'h0);
        for (int i = 0; i < 6; i++) begin
            apb_read(20'(i * 4), rd);
            check($sformatf("rst_read_%0d", i * 4), rd, 32'h0);
        end

        apb_write(20'h04, 32'hA5A5_0001);
        apb_read(20'h04, rd);
        check("data_in_rb", rd, 32'hA5A5_0001);
        check("data_in_port", data_in, 32'hA5A5_0001);
        apb_write(20'h0C, 32'hFFFF_FFFF);
        apb_read(20'h0C, rd);
        check("noise_rb", rd, 32'hFFFF_FFFF);
        apb_write(20'h08, 32'hFFFF_FFFE);
        apb_read(20'h08, rd);
        check("cw_width_narrow", rd, 32'h2);
        check("cw_width_port", {30'b0, codeword_width}, 32'h2);
        apb_write(20'h10, 32'h1111_1111);
        apb_read(20'h10, rd);
        check("data_out_ro", rd, 32'h0);
        apb_read(20'h18, rd);
        check("unmapped_18", rd, 32'h0);

        apb_write(20'h00, 32'h1);
        check("ctrl_op_start", {31'b0, op_start}, 32'h1);
        check("ctrl_busy", {31'b0, busy}, 32'h1);
        check("ctrl_port", {30'b0, ctrl}, 32'h1);
        @(negedge clk);
        check("op_start_one_cycle", {31'b0, op_start}, 32'h0);
        apb_read(20'h14, rd);
        check("status_busy", rd, 32'h1);

        slverr_seen = 1'b0;
        apb_write(20'h04, 32'h0000_DEAD);
`ifdef ECC_APB_PSLVERR_EN
        check("pslverr_busy_write", {31'b0, slverr_seen}, 32'h1);
`endif
        apb_read(20'h04, rd);
        check("data_in_busy_ignored", rd, 32'hA5A5_0001);

        @(negedge clk);
        core_done = 1'b1; core_data_out = 32'h1234; core_num_errors = 2'd1;
        @(negedge clk);
        core_done = 1'b0;
        check("done_busy_clear", {31'b0, busy}, 32'h0);
        apb_read(20'h10, rd);
        check("data_out", rd, 32'h1234);
        apb_read(20'h14, rd);
        check("status_errors", rd, 32'h2);

        @(negedge clk);
        core_done = 1'b1; core_data_out = 32'h9999; core_num_errors = 2'd2;
        @(negedge clk);
        core_done = 1'b0;
        apb_read(20'h10, rd);
        check("done_idle_ignored", rd, 32'h1234);

        apb_write(20'h00, 32'h2);
        check("ctrl2_busy", {31'b0, busy}, 32'h1);
        @(negedge clk);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 20'h00; PWDATA = 32'h1;
        @(negedge clk);
        PENABLE = 1'b1;
        core_done = 1'b1; core_data_out = 32'h55; core_num_errors = 2'd2;
        @(negedge clk);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; core_done = 1'b0;
        check("collide_no_start", {31'b0, op_start}, 32'h0);
        check("collide_busy_clear", {31'b0, busy}, 32'h0);
        apb_read(20'h00, rd);
        check("collide_ctrl_kept", rd, 32'h2);
        apb_read(20'h14, rd);
        check("collide_status", rd, 32'h4);

        apb_write(20'h00, 32'h3);
        check("ctrl3_no_start", {31'b0, op_start}, 32'h0);
        check("ctrl3_no_busy", {31'b0, busy}, 32'h0);
        check("ctrl3_stored", {30'b0, ctrl}, 32'h3);

        apb_write(20'h00, 32'h1);
        check("pre_rst_busy", {31'b0, busy}, 32'h1);
        apb_read(20'h04, rd);
        @(negedge clk);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 20'h00; PWDATA = 32'h2;
        @(negedge clk);
        PENABLE = 1'b1; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        check("midrst_ctrl", {30'b0, ctrl}, 32'h0);
        check("midrst_busy", {31'b0, busy}, 32'h0);
        check("midrst_op_start", {31'b0, op_start}, 32'h0);
        check("midrst_data_in", data_in, 32'h0);
        check("midrst_noise", noise, 32'h0);
        check("midrst_prdata", PRDATA, 32'h0);
        @(negedge clk);
        check("midrst_no_late_start", {31'b0, op_start}, 32'h0);
        apb_read(20'h10, rd);
        check("midrst_data_out", rd, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
